// File: rtl/commit_trace_unit_pkg.sv
// rtl/commit_trace_unit_pkg.sv - shared trace record types and kind encoder
package commit_trace_unit_pkg;

    localparam int KIND_W = 3;
    localparam int INUM_W = 32;
    localparam int PC_W   = 16;
    localparam int REG_W  = 4;
    localparam int VAL_W  = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [KIND_W-1:0] {
        TR_REGW  = 3'd0,
        TR_LOAD  = 3'd1,
        TR_STORE = 3'd2,
        TR_OTHER = 3'd3,
        TR_HALT  = 3'd4
    } tr_kind_e;

    typedef struct packed {
        tr_kind_e            kind;
        logic [INUM_W-1:0]   inum;
        logic [PC_W-1:0]     pc;
        logic [REG_W-1:0]    rg;
        logic [VAL_W-1:0]    value;
        logic [ADDR_W-1:0]   addr;
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);

    // A load also writes a register, so it must win over plain REGW.
    function automatic tr_kind_e encode_kind(input logic regwr, input logic memrd,
                                             input logic memwr, input logic hlt);
        if (regwr && memrd) return TR_LOAD;
        if (regwr)          return TR_REGW;
        if (hlt)            return TR_HALT;
        if (memwr)          return TR_STORE;
        return TR_OTHER;
    endfunction

endpackage

// File: rtl/commit_trace_unit_fifo.sv
// rtl/commit_trace_unit_fifo.sv - synchronous record FIFO with wrap-bit pointers
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_en_i,
    output logic [W-1:0] rd_data_o,
    output logic         rd_valid_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr_q, rptr_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_rd, do_wr;

    assign empty_o    = (wptr_q == rptr_q);
    assign full_o     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rd_valid_o = ~empty_o;
    assign rd_data_o  = mem_q[rptr_q[AW-1:0]];

    // A write into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_rd = rd_en_i & ~empty_o;
    assign do_wr = wr_en_i & (~full_o | do_rd);

    // Pointer update; reset empties the FIFO without touching storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + 1'b1;
            if (do_rd) rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/commit_trace_unit.sv
// rtl/commit_trace_unit.sv - retire-point commit to trace record stream converter
module commit_trace_unit
    import commit_trace_unit_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int MAX_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmt_valid,
    input  logic [15:0] cmt_pc,
    input  logic        cmt_regwr,
    input  logic [3:0]  cmt_wreg,
    input  logic [15:0] cmt_wdata,
    input  logic        cmt_memrd,
    input  logic        cmt_memwr,
    input  logic [15:0] cmt_addr,
    input  logic [15:0] cmt_mdata,
    input  logic        cmt_hlt,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [2:0]  rec_kind,
    output logic [31:0] rec_inum,
    output logic [15:0] rec_pc,
    output logic [3:0]  rec_reg,
    output logic [15:0] rec_value,
    output logic [15:0] rec_addr,
    output logic [31:0] cycle_cnt,
    output logic [31:0] inst_cnt,
    output logic [15:0] drop_cnt,
    output logic        overflow,
    output logic        done,
    output logic        timeout
);
    localparam logic [31:0] MAX_C = 32'(MAX_CYCLES);

    trace_rec_t  new_rec, push_rec, head_rec, rec_view, hold_q, hold_d;
    logic        hold_valid_q, hold_valid_d, halted_q, halted_d;
    logic        timeout_q, timeout_d, overflow_q, overflow_d, done_q, done_d;
    logic [31:0] cycle_q, cycle_d, inst_q, inst_d;
    logic [15:0] drop_q, drop_d;
    logic        accept, pop, space, push_en, fifo_full, fifo_empty, fifo_valid;
    logic [REC_W-1:0] head_bits;

    assign accept = cmt_valid & ~halted_q & ~timeout_q;
    assign pop    = fifo_valid & rec_ready;
    assign space  = ~fifo_full | pop;

    // Build the record for this cycle's commit; unused fields are zeroed per kind.
    always_comb begin
        new_rec      = '0;
        new_rec.kind = encode_kind(cmt_regwr, cmt_memrd, cmt_memwr, cmt_hlt);
        new_rec.inum = inst_q;
        new_rec.pc   = cmt_pc;
        case (new_rec.kind)
            TR_REGW: begin
                new_rec.rg    = cmt_wreg;
                new_rec.value = cmt_wdata;
            end
            TR_LOAD: begin
                new_rec.rg    = cmt_wreg;
                new_rec.value = cmt_wdata;
                new_rec.addr  = cmt_addr;
            end
            TR_STORE: begin
                new_rec.value = cmt_mdata;
                new_rec.addr  = cmt_addr;
            end
            default: ;
        endcase
    end

    // Push arbitration, halt holding, counters and sticky flags.
    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        halted_d     = halted_q;
        timeout_d    = timeout_q;
        overflow_d   = overflow_q;
        inst_d       = inst_q;
        drop_d       = drop_q;
        cycle_d      = cycle_q;
        push_en      = 1'b0;
        push_rec     = new_rec;
        if (hold_valid_q) begin
            // Only a held HALT can be pending; nothing is accepted after it.
            push_rec = hold_q;
            if (space) begin
                push_en      = 1'b1;
                hold_valid_d = 1'b0;
            end
        end else if (accept) begin
            inst_d = inst_q + 32'd1;
            if (new_rec.kind == TR_HALT) halted_d = 1'b1;
            if (space) begin
                push_en = 1'b1;
            end else if (new_rec.kind == TR_HALT) begin
                hold_d       = new_rec;
                hold_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
                if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            end
        end
        if (cycle_q != MAX_C) begin
            cycle_d = cycle_q + 32'd1;
            if (cycle_d == MAX_C && !halted_q) timeout_d = 1'b1;
        end
        done_d = done_q | (pop & (head_rec.kind == TR_HALT));
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            timeout_q    <= 1'b0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
            inst_q       <= '0;
            drop_q       <= '0;
            cycle_q      <= '0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            halted_q     <= halted_d;
            timeout_q    <= timeout_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
            inst_q       <= inst_d;
            drop_q       <= drop_d;
            cycle_q      <= cycle_d;
        end
    end

    trace_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (push_en),
        .wr_data_i  (push_rec),
        .rd_en_i    (pop),
        .rd_data_o  (head_bits),
        .rd_valid_o (fifo_valid),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign head_rec = head_bits;
    // Stale storage must not leak onto the outputs while the FIFO is empty.
    assign rec_view = (fifo_valid && !fifo_empty) ? head_rec : '0;

    assign rec_valid = fifo_valid;
    assign rec_kind  = rec_view.kind;
    assign rec_inum  = rec_view.inum;
    assign rec_pc    = rec_view.pc;
    assign rec_reg   = rec_view.rg;
    assign rec_value = rec_view.value;
    assign rec_addr  = rec_view.addr;
    assign cycle_cnt = cycle_q;
    assign inst_cnt  = inst_q;
    assign drop_cnt  = drop_q;
    assign overflow  = overflow_q;
    assign done      = done_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_commit_trace_unit.sv
// tb/tb_commit_trace_unit.sv - directed self-checking bench for commit_trace_unit
module tb_commit_trace_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmt_valid = 1'b0, cmt_regwr = 1'b0, cmt_memrd = 1'b0, cmt_memwr = 1'b0, cmt_hlt = 1'b0;
    logic [15:0] cmt_pc = '0, cmt_wdata = '0, cmt_addr = '0, cmt_mdata = '0;
    logic [3:0]  cmt_wreg = '0;
    logic        rec_ready = 1'b0;

    logic        rec_valid, overflow, done, timeout;
    logic [2:0]  rec_kind;
    logic [31:0] rec_inum, cycle_cnt, inst_cnt;
    logic [15:0] rec_pc, rec_value, rec_addr, drop_cnt;
    logic [3:0]  rec_reg;

    logic        wd_rec_valid, wd_overflow, wd_done, wd_timeout;
    logic [2:0]  wd_rec_kind;
    logic [31:0] wd_rec_inum, wd_cycle_cnt, wd_inst_cnt;
    logic [15:0] wd_rec_pc, wd_rec_value, wd_rec_addr, wd_drop_cnt;
    logic [3:0]  wd_rec_reg;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    commit_trace_unit #(.DEPTH(8), .MAX_CYCLES(100000)) dut (
        .clk(clk), .rst(rst), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_regwr(cmt_regwr),
        .cmt_wreg(cmt_wreg), .cmt_wdata(cmt_wdata), .cmt_memrd(cmt_memrd), .cmt_memwr(cmt_memwr),
        .cmt_addr(cmt_addr), .cmt_mdata(cmt_mdata), .cmt_hlt(cmt_hlt),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind), .rec_inum(rec_inum),
        .rec_pc(rec_pc), .rec_reg(rec_reg), .rec_value(rec_value), .rec_addr(rec_addr),
        .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt), .drop_cnt(drop_cnt), .overflow(overflow),
        .done(done), .timeout(timeout)
    );

    commit_trace_unit #(.DEPTH(8), .MAX_CYCLES(20)) dut_wd (
        .clk(clk), .rst(rst), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_regwr(cmt_regwr),
        .cmt_wreg(cmt_wreg), .cmt_wdata(cmt_wdata), .cmt_memrd(cmt_memrd), .cmt_memwr(cmt_memwr),
        .cmt_addr(cmt_addr), .cmt_mdata(cmt_mdata), .cmt_hlt(cmt_hlt),
        .rec_valid(wd_rec_valid), .rec_ready(rec_ready), .rec_kind(wd_rec_kind), .rec_inum(wd_rec_inum),
        .rec_pc(wd_rec_pc), .rec_reg(wd_rec_reg), .rec_value(wd_rec_value), .rec_addr(wd_rec_addr),
        .cycle_cnt(wd_cycle_cnt), .inst_cnt(wd_inst_cnt), .drop_cnt(wd_drop_cnt), .overflow(wd_overflow),
        .done(wd_done), .timeout(wd_timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] pc, input logic rw, input logic [3:0] wr,
                         input logic [15:0] wd, input logic mr, input logic mw,
                         input logic [15:0] ad, input logic [15:0] md, input logic h);
        cmt_valid = v;  cmt_pc = pc;   cmt_regwr = rw; cmt_wreg = wr; cmt_wdata = wd;
        cmt_memrd = mr; cmt_memwr = mw; cmt_addr = ad; cmt_mdata = md; cmt_hlt = h;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rec_ready = 1'b0;
        drive(0, 16'h0, 0, 4'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (rec_valid !== 1'b0) begin fails++; $display("FAIL reset_rec_valid got %0d want 0", rec_valid); end
        tests++; if (cycle_cnt !== 32'd0) begin fails++; $display("FAIL reset_cycle_cnt got %0d want 0", cycle_cnt); end
        tests++; if (inst_cnt !== 32'd0) begin fails++; $display("FAIL reset_inst_cnt got %0d want 0", inst_cnt); end
        tests++; if (drop_cnt !== 16'd0) begin fails++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
        tests++; if ({done, timeout, overflow} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {done, timeout, overflow}); end
    endtask

    task automatic test_regw();
        do_reset();
        rec_ready = 1'b1;
        drive(1, 16'h0002, 1, 4'd3, 16'h00AB, 0, 0, 16'h0, 16'h0, 0);
        step();
        drive(0, 16'h0, 0, 4'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
        tests++; if (rec_valid !== 1'b1) begin fails++; $display("FAIL regw_valid got %0d want 1", rec_valid); end
        tests++; if ({rec_kind, rec_inum, rec_pc, rec_reg, rec_value, rec_addr} !== {3'd0, 32'd0, 16'h0002, 4'd3, 16'h00AB, 16'h0000})
            begin fails++; $display("FAIL regw_rec got k=%0d i=%0d pc=%h r=%0d v=%h a=%h want k=0 i=0 pc=0002 r=3 v=00ab a=0000",
                                    rec_kind, rec_inum, rec_pc, rec_reg, rec_value, rec_addr); end
        tests++; if (inst_cnt !== 32'd1) begin fails++; $display("FAIL regw_inst_cnt got %0d want 1", inst_cnt); end
        step();
        tests++; if (rec_valid !== 1'b0) begin fails++; $display("FAIL regw_popped got %0d want 0", rec_valid); end
    endtask

    task automatic test_load_store();
        do_reset();
        drive(1, 16'h0004, 1, 4'd5, 16'h5555, 1, 0, 16'h0010, 16'h0, 0);
        step();
        drive(1, 16'h0006, 0, 4'd0, 16'h0, 0, 1, 16'h0020, 16'h1234, 0);
        step();
        drive(0, 16'h0, 0, 4'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
        rec_ready = 1'b1;
        tests++; if ({rec_kind, rec_inum, rec_pc, rec_reg, rec_value, rec_addr} !== {3'd1, 32'd0, 16'h0004, 4'd5, 16'h5555, 16'h0010})
            begin fails++; $display("FAIL load_rec got k=%0d i=%0d pc=%h r=%0d v=%h a=%h want k=1 i=0 pc=0004 r=5 v=5555 a=0010",
                                    rec_kind, rec_inum, rec_pc, rec_reg, rec_value, rec_addr); end
        step();
        tests++; if ({rec_kind, rec_inum, rec_pc, rec_reg, rec_value, rec_addr} !== {3'd2, 32'd1, 16'h0006, 4'd0, 16'h1234, 16'h0020})
            begin fails++; $display("FAIL store_rec got k=%0d i=%0d pc=%h r=%0d v=%h a=%h want k=2 i=1 pc=0006 r=0 v=1234 a=0020",
                                    rec_kind, rec_inum, rec_pc, rec_reg, rec_value, rec_addr); end
        step();
        tests++; if (rec_valid !== 1'b0) begin fails++; $display("FAIL ls_drained got %0d want 0", rec_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1, 16'(2 * i), 0, 4'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
            step();
        end
        drive(0, 16'h0, 0, 4'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
        tests++; if (drop_cnt !== 16'd2) begin fails++; $display("FAIL ovf_drop_cnt got %0d want 2", drop_cnt); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %0d want 1", overflow); end
        tests++; if (inst_cnt !== 32'd10) begin fails++; $display("FAIL ovf_inst_cnt got %0d want 10", inst_cnt); end
        step();
        tests++; if ({rec_valid, rec_inum} !== {1'b1, 32'd0}) begin fails++; $display("FAIL ovf_hold_stable got v=%0d i=%0d want v=1 i=0", rec_valid, rec_inum); end
        rec_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if ({rec_valid, rec_kind, rec_inum, rec_pc} !== {1'b1, 3'd3, 32'(i), 16'(2 * i)}) begin
                fails++; $display("FAIL ovf_drain_%0d got v=%0d k=%0d i=%0d pc=%h want v=1 k=3 i=%0d pc=%h",
                                  i, rec_valid, rec_kind, rec_inum, rec_pc, i, 16'(2 * i));
            end
            step();
        end
        tests++; if (rec_valid !== 1'b0) begin fails++; $display("FAIL ovf_empty got %0d want 0", rec_valid); end
    endtask

    task automatic test_halt_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 16'(2 * i), 0, 4'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
            step();
        end
        drive(1, 16'h0100, 0, 4'h0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
        step();
        drive(1, 16'h0102, 1, 4'd7, 16'hBEEF, 0, 0, 16'h0, 16'h0, 0);
        step();
        drive(0, 16'h0, 0, 4'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
        tests++; if (inst_cnt !== 32'd9) begin fails++; $display("FAIL halt_inst_cnt got %0d want 9", inst_cnt); end
        tests++; if ({overflow, drop_cnt} !== {1'b0, 16'd0}) begin fails++; $display("FAIL halt_no_drop got ovf=%0d drop=%0d want 0 0", overflow, drop_cnt); end
        rec_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tests++;
            if ({rec_valid, rec_inum} !== {1'b1, 32'(i)}) begin
                fails++; $display("FAIL halt_drain_%0d got v=%0d i=%0d want v=1 i=%0d", i, rec_valid, rec_inum, i);
            end
            if (i == 8) begin
                tests++; if ({rec_kind, rec_pc} !== {3'd4, 16'h0100}) begin fails++; $display("FAIL halt_rec got k=%0d pc=%h want k=4 pc=0100", rec_kind, rec_pc); end
                tests++; if (done !== 1'b0) begin fails++; $display("FAIL halt_done_early got %0d want 0", done); end
            end
            step();
        end
        tests++; if ({done, rec_valid} !== 2'b10) begin fails++; $display("FAIL halt_done got done=%0d v=%0d want 1 0", done, rec_valid); end
        step();
        tests++; if ({done, inst_cnt} !== {1'b1, 32'd9}) begin fails++; $display("FAIL halt_done_hold got done=%0d inst=%0d want 1 9", done, inst_cnt); end
    endtask

    task automatic test_watchdog();
        do_reset();
        repeat (17) step();
        drive(1, 16'h0040, 0, 4'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
        step();
        drive(0, 16'h0, 0, 4'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
        step();
        tests++; if ({wd_cycle_cnt, wd_timeout} !== {32'd19, 1'b0}) begin fails++; $display("FAIL wd_pre got cyc=%0d to=%0d want 19 0", wd_cycle_cnt, wd_timeout); end
        step();
        tests++; if ({wd_cycle_cnt, wd_timeout} !== {32'd20, 1'b1}) begin fails++; $display("FAIL wd_hit got cyc=%0d to=%0d want 20 1", wd_cycle_cnt, wd_timeout); end
        drive(1, 16'h0050, 0, 4'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
        repeat (3) step();
        drive(0, 16'h0, 0, 4'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
        tests++; if ({wd_cycle_cnt, wd_inst_cnt} !== {32'd20, 32'd1}) begin fails++; $display("FAIL wd_ignored got cyc=%0d inst=%0d want 20 1", wd_cycle_cnt, wd_inst_cnt); end
        tests++; if ({wd_rec_valid, wd_rec_inum, wd_rec_pc} !== {1'b1, 32'd0, 16'h0040}) begin fails++; $display("FAIL wd_buffered got v=%0d i=%0d pc=%h want 1 0 0040", wd_rec_valid, wd_rec_inum, wd_rec_pc); end
        rec_ready = 1'b1;
        step();
        rec_ready = 1'b0;
        tests++; if (wd_rec_valid !== 1'b0) begin fails++; $display("FAIL wd_drain got %0d want 0", wd_rec_valid); end
        tests++; if (rec_valid !== 1'b1) begin fails++; $display("FAIL mid_pre got %0d want 1", rec_valid); end
        rst = 1'b1;
        step();
        tests++; if ({rec_valid, inst_cnt, wd_cycle_cnt, wd_timeout, wd_inst_cnt} !== {1'b0, 32'd0, 32'd0, 1'b0, 32'd0})
            begin fails++; $display("FAIL mid_reset got v=%0d inst=%0d cyc=%0d to=%0d wdinst=%0d want all 0",
                                    rec_valid, inst_cnt, wd_cycle_cnt, wd_timeout, wd_inst_cnt); end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_regw();
        test_load_store();
        test_overflow();
        test_halt_full();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
